// File: rtl/cla_pipe_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cla_pipe_adder                                                           |
// | Pipelined carry-lookahead add/sub; one 4-bit group resolved per stage.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cla_pipe_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_P,
  output logic             out_G,
  output logic             out_ovf
);

  localparam int NG = WIDTH / 4;

  // Packed result: {P_grp, G_grp, carry into bit 3, carry out, sum[3:0]}
  function automatic logic [7:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic c);
    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] cv;
    logic       gg;
    logic       pg;
    p     = a ^ b;
    g     = a & b;
    cv[0] = c;
    cv[1] = g[0] | (p[0] & c);
    cv[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
    cv[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
    gg    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    pg    = &p;
    cv[4] = gg | (pg & c);
    return {pg, gg, cv[3], cv[4], p ^ cv[3:0]};
  endfunction

  logic [WIDTH-1:0] r_a   [0:NG-1];
  logic [WIDTH-1:0] r_b   [0:NG-1];
  logic             r_c   [0:NG];
  logic             r_v   [0:NG];
  logic [WIDTH-1:0] r_sum [1:NG];
  logic             r_p   [1:NG];
  logic             r_g   [1:NG];
  logic             r_cm;

  logic [7:0]       w_grp [1:NG];
  logic [WIDTH-1:0] w_sum [1:NG];
  logic             w_p   [1:NG];
  logic             w_g   [1:NG];

  generate
    for (genvar k = 1; k <= NG; k++) begin : g_group
      assign w_grp[k] = cla4(r_a[k-1][4*(k-1) +: 4], r_b[k-1][4*(k-1) +: 4], r_c[k-1]);
      if (k == 1) begin : g_first
        assign w_p[k]   = w_grp[k][7];
        assign w_g[k]   = w_grp[k][6];
        assign w_sum[k] = WIDTH'(w_grp[k][3:0]);
      end else begin : g_next
        assign w_p[k]   = r_p[k-1] & w_grp[k][7];
        assign w_g[k]   = w_grp[k][6] | (w_grp[k][7] & r_g[k-1]);
        // Bits above the processed groups are always zero in the skewed sum
        assign w_sum[k] = r_sum[k-1] | (WIDTH'(w_grp[k][3:0]) << (4*(k-1)));
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NG; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
      end
      for (int k = 0; k <= NG; k++) begin
        r_c[k] <= 1'b0;
        r_v[k] <= 1'b0;
      end
      for (int k = 1; k <= NG; k++) begin
        r_sum[k] <= '0;
        r_p[k]   <= 1'b0;
        r_g[k]   <= 1'b0;
      end
      r_cm <= 1'b0;
    end else if (en) begin
      r_a[0] <= in_a;
      r_b[0] <= sub ? ~in_b : in_b;
      r_c[0] <= cin ^ sub;
      r_v[0] <= in_valid;
      for (int k = 1; k < NG; k++) begin
        r_a[k]   <= r_a[k-1];
        r_b[k]   <= r_b[k-1];
        r_c[k]   <= w_grp[k][4];
        r_sum[k] <= w_sum[k];
        r_p[k]   <= w_p[k];
        r_g[k]   <= w_g[k];
        r_v[k]   <= r_v[k-1];
      end
      // Last stage doubles as the output register: it only loads real results
      r_v[NG] <= r_v[NG-1];
      if (r_v[NG-1]) begin
        r_sum[NG] <= w_sum[NG];
        r_c[NG]   <= w_grp[NG][4];
        r_p[NG]   <= w_p[NG];
        r_g[NG]   <= w_g[NG];
        r_cm      <= w_grp[NG][5];
      end
    end
  end

  assign out_valid = r_v[NG];
  assign out_sum   = r_sum[NG];
  assign out_cout  = r_c[NG];
  assign out_P     = r_p[NG];
  assign out_G     = r_g[NG];
  assign out_ovf   = r_cm ^ r_c[NG];

endmodule
`default_nettype wire

// File: doc/cla_pipe_adder.md
# cla_pipe_adder

Parametrised, fully pipelined carry-lookahead adder/subtractor: the multi-group successor to the team's registered 4-bit CLA block. Each pipeline stage resolves one 4-bit lookahead group and passes the group carry to the next stage, so the block sustains one operation per clock at any width. It exports block-level propagate/generate for higher-level lookahead, plus carry-out and signed overflow. It sits between operand registers and the ALU result mux.

## Interface
- WIDTH, 16, operand width; multiple of 4, range 4..64; NG = WIDTH/4 groups
- clk  input  1  clock; all registers update on rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  pipeline advance; low = every register holds
- in_valid  input  1  operands on in_a/in_b/cin/sub are a valid operation
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- cin  input  1  carry-in
- sub  input  1  1 = subtract: B inverted, effective carry-in = cin ^ 1
- out_valid  output  1  out_* hold a new result this cycle
- out_sum  output  WIDTH  sum/difference
- out_cout  output  1  carry-out of MSB (sub: 1 = no borrow)
- out_P  output  1  block propagate = AND of all bit propagates (a ^ b')
- out_G  output  1  block generate, independent of carry-in
- out_ovf  output  1  signed overflow = carry into MSB XOR out_cout

## Operation
- Stage 0 (input register): on an edge with en=1, capture in_a, b' = sub ? ~in_b : in_b, c0 = cin ^ sub, and in_valid into v0.
- Stage k (k = 1..NG): group k-1 (bits 4(k-1)+3..4(k-1)) computed with 4-bit lookahead from stage k-1 operands and the carry registered at stage k-1; registers group sum, group carry-out, running P (AND) and G (G_grp | P_grp & G_prev), valid bit.
- Operand bits of groups not yet processed and sums of groups already processed travel through skew registers alongside; no group is computed twice.
- Carry into MSB is retained in the last stage for out_ovf.
- Stage NG register is the output register: out_* load only when the stage-NG valid bit is 1; otherwise out_sum/out_cout/out_P/out_G/out_ovf hold their previous values and out_valid = 0.
- in_valid=0 inserts a bubble; bubbles propagate and never produce out_valid.
- en=0: all stage, skew and output registers hold, including out_valid; a held out_valid=1 remains high (consumer must qualify with en).
- rst=1 (with or without en): all registers including valid bits and outputs clear to 0 on the next edge; in-flight operations are discarded.
- Arithmetic modulo 2^WIDTH; out_cout is bit WIDTH of a + b' + c0.

## Timing
- Latency L = NG + 1 rising edges with en=1: operands present at edge E0 appear on outputs after edge E0+L-1... i.e. valid in the cycle following edge E0+NG. WIDTH=4 gives 2; WIDTH=16 gives 5.
- Throughput: one operation per en=1 cycle; back-to-back results are in order, no gaps except inserted bubbles or en=0 cycles.
- en=0 cycles extend latency one-for-one.
- Reset values: out_sum=0, out_cout=0, out_P=0, out_G=0, out_ovf=0, out_valid=0; out_valid stays 0 for at least L en=1 edges after rst deasserts unless inputs are valid.
- Critical path: one 4-bit group plus P/G merge; independent of WIDTH.

## Test plan
- Reset: drive rst=1 two cycles with random inputs -> all outputs 0, out_valid 0; deassert, in_valid=0 -> outputs stay 0.
- WIDTH=16 add: a=0x1234, b=0x4321, cin=0 -> exactly 5 edges later out_valid=1, sum=0x5555, cout=0, P=0, G=0, ovf=0.
- Carry chain: a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, P=1, G=0; a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, G=1, ovf=0; a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
- Subtract: sub=1, a=0x0005, b=0x0007, cin=0 -> sum=0xFFFE, cout=0; a=0x0007, b=0x0005 -> sum=0x0002, cout=1.
- Streaming: 20 random back-to-back ops with in_valid gaps and en low for 3 random cycles -> results match reference model in order, out_valid only for valid inputs, outputs hold across bubbles and en=0.
- Reset mid-stream plus width sweep: assert rst with 4 ops in flight -> none emerge; repeat directed cases at WIDTH=4 (latency 2) and WIDTH=64 (latency 17).
